uart_ascii_tx: RTL and testbench
================================

Name: uart_ascii_tx

Overview:
Serial transmitter directly downstream of the hex-to-ASCII converter. It accepts 8-bit ASCII codes through a valid/ready handshake, buffers one byte, and shifts each byte out as an 8N1 UART frame, LSB first, on a single TX line to the host PC. This lets the DSP datapath stream converted sample digits without stalling on every bit time.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 2.
CNT_W, 13, baud counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
ascii_code  input  8  byte to transmit, normally the converter's output.
data_valid  input  1  ascii_code is valid this cycle.
data_ready  output  1  block can accept a byte this cycle.
tx  output  1  serial line, idle high.
tx_busy  output  1  a frame is in progress (any state other than IDLE).
tx_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-frame): tx=1, data_ready=1, tx_busy=0, tx_done=0. FSM goes to IDLE, holding buffer is emptied, all counters are cleared.
- Handshake: a byte is accepted on a rising edge where data_valid && data_ready.
  - data_ready = !buf_full; it is combinational from registered state only and does not depend on data_valid.
- Holding buffer: one 8-bit entry plus a buf_full flag.
- FSM states and transitions:
  - IDLE → START. If the buffer is full, or a byte is accepted this edge, the byte is loaded into the shift register and tx drops to 0 on that same edge.
    - A byte accepted while in IDLE bypasses the buffer, so buf_full stays 0.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: shift out 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit counter runs 0..7, then → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, tx_done=1 for that cycle.
    - If buf_full: load the buffer into the shift register, clear buf_full, and go → START on the same edge. There is no idle gap between frames.
    - Otherwise → IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Accepting a byte in START, DATA or STOP writes the holding buffer and sets buf_full.
- Boundary conditions:
  - Buffer full and the frame ends on the same edge: data_ready is 0 in that cycle, so no accept. data_ready rises the next cycle.
  - data_valid while data_ready=0: the byte is ignored, not queued. The upstream stage must hold it.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
- tx, tx_busy and tx_done are registered outputs with no combinational path from the inputs.

Optional Feature:
Macro name: UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving 8E1 frames of 11 bits.
- Not defined: no PARITY state exists and frames are 8N1. The parity logic is removed entirely.

Decomposition:
- Package uart_pkg holds:
  - the state encoding constants: IDLE, START, DATA, PARITY, STOP;
  - the frame-bit-count constants: 10, and 11 with parity;
  - the idle line level constant.
- One natural sub-module, uart_baud_tick. It contains the CNT_W counter, takes a restart input, and outputs a bit_end strobe on count CLKS_PER_BIT-1. The FSM and buffer stay in uart_ascii_tx.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
- Reset, then idle for 20 cycles → tx=1, data_ready=1, tx_busy=0, tx_done=0 throughout.
- Single byte 8'h41 ('A') accepted at cycle T →
  - tx waveform is 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles, starting at T+1;
  - tx_done pulses at T+40;
  - tx_busy is low from T+41.
- Bytes 8'h30 and 8'h46 sent back to back, the second accepted during the first frame →
  - data_ready is 0 after the second accept;
  - the second start bit immediately follows the first stop bit (80 contiguous busy cycles);
  - two tx_done pulses, 40 cycles apart.
- Third byte 8'h31 held valid while the buffer is full → not accepted until the cycle after the first frame's tx_done. The bytes emerge in order 30, 46, 31 with none lost or duplicated.
- Reset asserted mid-DATA of 8'hA0 with the buffer full →
  - tx=1 and data_ready=1 immediately;
  - after release, no residual frame is sent and a fresh byte 8'h39 transmits correctly.
- With UART_PARITY_EN: send 8'h43 (3 ones) → parity bit 1, frame 44 cycles. Send 8'h33 (4 ones) → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the ASCII UART transmitter: FSM state encoding,
// frame lengths, idle line level and the even-parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Bits per frame: start + 8 data + stop, plus one when parity is enabled.
    localparam int unsigned FRAME_BITS     = 10;
    localparam int unsigned FRAME_BITS_PAR = 11;

    // Level of the serial line between frames and during the stop bit.
    localparam logic IDLE_LEVEL = 1'b1;

    // Even parity over one data byte (1 when the byte has an odd number of ones).
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps on every bit boundary; restart holds it at zero so the first bit of
// a frame is a full bit long.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Bit-time counter: cleared by restart or at the end of each bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (restart || bit_end) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign bit_end     = (cnt_r == CNT_LAST);
    assign bit_pre_end = (cnt_r == CNT_PRE);

endmodule

// File: rtl/uart_ascii_tx.sv
// UART transmitter for ASCII bytes: valid/ready input, one-entry holding
// buffer, 8N1 frames LSB first. Define UART_PARITY_EN to insert an even
// parity bit and send 8E1 frames.
module uart_ascii_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_code,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_t state_r, state_s;
    logic [7:0]  shift_r, shift_s;
    logic [2:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]  buf_r, buf_s;
    logic        buf_full_r, buf_full_s;
    logic        tx_r, tx_s;
    logic        tx_busy_r;
    logic        tx_done_r;
    logic        accept_s;
    logic        load_s;
    logic        restart_s;
    logic        bit_end_s;
    logic        bit_pre_end_s;
`ifdef UART_PARITY_EN
    logic        parity_r, parity_s;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart_s),
        .bit_end    (bit_end_s),
        .bit_pre_end(bit_pre_end_s)
    );

    assign accept_s  = data_valid && !buf_full_r;
    // Hold the baud counter at zero while idle so the start bit is full length.
    assign restart_s = (state_r == IDLE);

    // Next-state, shift register, holding buffer and line level.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        buf_s      = buf_r;
        buf_full_s = buf_full_r;
        tx_s       = tx_r;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                tx_s = IDLE_LEVEL;
                if (buf_full_r) begin
                    shift_s    = buf_r;
                    buf_full_s = 1'b0;
                    load_s     = 1'b1;
                    state_s    = START;
                    tx_s       = 1'b0;
                end else if (accept_s) begin
                    // Bypass the buffer: straight into the shift register.
                    shift_s = ascii_code;
                    load_s  = 1'b1;
                    state_s = START;
                    tx_s    = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (accept_s) begin
                    buf_s      = ascii_code;
                    buf_full_s = 1'b1;
                end else begin
                    buf_full_s = buf_full_r;
                end
                if (bit_end_s) begin
                    state_s   = DATA;
                    bit_cnt_s = 3'd0;
                    tx_s      = shift_r[0];
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (accept_s) begin
                    buf_s      = ascii_code;
                    buf_full_s = 1'b1;
                end else begin
                    buf_full_s = buf_full_r;
                end
                if (bit_end_s && (bit_cnt_r == 3'd7)) begin
`ifdef UART_PARITY_EN
                    state_s = PARITY;
                    tx_s    = parity_r;
`else
                    state_s = STOP;
                    tx_s    = IDLE_LEVEL;
`endif
                end else if (bit_end_s) begin
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    shift_s   = {1'b0, shift_r[7:1]};
                    tx_s      = shift_r[1];
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (accept_s) begin
                    buf_s      = ascii_code;
                    buf_full_s = 1'b1;
                end else begin
                    buf_full_s = buf_full_r;
                end
                if (bit_end_s) begin
                    state_s = STOP;
                    tx_s    = IDLE_LEVEL;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_end_s && buf_full_r) begin
                    // Back-to-back frame from the holding buffer, no idle gap.
                    shift_s    = buf_r;
                    buf_full_s = 1'b0;
                    load_s     = 1'b1;
                    state_s    = START;
                    tx_s       = 1'b0;
                end else if (bit_end_s && accept_s) begin
                    shift_s = ascii_code;
                    load_s  = 1'b1;
                    state_s = START;
                    tx_s    = 1'b0;
                end else if (bit_end_s) begin
                    state_s = IDLE;
                    tx_s    = IDLE_LEVEL;
                end else if (accept_s) begin
                    buf_s      = ascii_code;
                    buf_full_s = 1'b1;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s    = IDLE;
                buf_full_s = 1'b0;
                tx_s       = IDLE_LEVEL;
            end
        endcase
    end

`ifdef UART_PARITY_EN
    // Parity of the byte just loaded into the shift register.
    always_comb begin
        if (load_s) begin
            parity_s = even_parity(shift_s);
        end else begin
            parity_s = parity_r;
        end
    end
`endif

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            buf_r      <= 8'h00;
            buf_full_r <= 1'b0;
            tx_r       <= IDLE_LEVEL;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            buf_r      <= buf_s;
            buf_full_r <= buf_full_s;
            tx_r       <= tx_s;
            tx_busy_r  <= (state_s != IDLE);
            // Registered so it is high exactly during the last stop-bit cycle.
            tx_done_r  <= (state_r == STOP) && bit_pre_end_s;
`ifdef UART_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    assign data_ready = !buf_full_r;
    assign tx         = tx_r;
    assign tx_busy    = tx_busy_r;
    assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_uart_ascii_tx.sv
// Directed self-checking bench for uart_ascii_tx with CLKS_PER_BIT=4.
// Define UART_PARITY_EN to also exercise 8E1 frames.
module tb_uart_ascii_tx;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ascii_code = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_ascii_tx #(.CLKS_PER_BIT(CPB), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .ascii_code(ascii_code),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line bits in time order (bit 0 first): start, data LSB first, [parity], stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
`ifdef UART_PARITY_EN
        f = {1'b1, ^b, b, 1'b0};
`else
        f = {1'b0, 1'b1, b, 1'b0};
`endif
        return f;
    endfunction

    // Idle-line checks for n cycles.
    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_ready", 32'(data_ready), 32'd1);
            check("idle_busy", 32'(tx_busy), 32'd0);
            check("idle_done", 32'(tx_done), 32'd0);
            @(negedge clk);
        end
    endtask

    // Offer one byte in idle (cycle T) and check the whole frame that follows.
    task automatic send_frame(input logic [7:0] b, input logic [10:0] bits);
        check("send_ready", 32'(data_ready), 32'd1);
        ascii_code = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 1; k <= FLEN; k++) begin
            check("frame_tx", 32'(tx), 32'(bits[(k-1)/CPB]));
            check("frame_busy", 32'(tx_busy), 32'd1);
            check("frame_done", 32'(tx_done), 32'(k == FLEN));
            @(negedge clk);
        end
        check("after_busy", 32'(tx_busy), 32'd0);
        check("after_tx", 32'(tx), 32'd1);
        check("after_done", 32'(tx_done), 32'd0);
    endtask

    initial begin
        logic [10:0] f3 [3];
        int          fi;

        // Reset, then 20 idle cycles.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(data_ready), 32'd1);
        reset = 1'b0;
        check_idle(20);

        // Single 'A': 0,1,0,0,0,0,0,1,0,1 in 8N1.
        send_frame(8'h41, exp_frame(8'h41));
        @(negedge clk);
        check_idle(3);

        // Back-to-back 30, 46, then 31 held while the buffer is full.
        f3[0] = exp_frame(8'h30);
        f3[1] = exp_frame(8'h46);
        f3[2] = exp_frame(8'h31);
        ascii_code = 8'h30;
        data_valid = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 3 * FLEN; k++) begin
            fi = (k - 1) / FLEN;
            check("b2b_tx", 32'(tx), 32'(f3[fi][((k-1) % FLEN) / CPB]));
            check("b2b_busy", 32'(tx_busy), 32'd1);
            check("b2b_done", 32'(tx_done), 32'((k % FLEN) == 0));
            check("b2b_ready", 32'(data_ready),
                  32'((k == 1) || (k == FLEN + 1) || (k > 2 * FLEN)));
            if (k == 1) begin
                ascii_code = 8'h46;
            end else if (k == 2) begin
                ascii_code = 8'h31;
            end else if (k == FLEN + 2) begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_end_busy", 32'(tx_busy), 32'd0);
        check("b2b_end_tx", 32'(tx), 32'd1);
        check_idle(5);

        // Reset mid-DATA of A0 with 55 sitting in the buffer.
        ascii_code = 8'hA0;
        data_valid = 1'b1;
        @(negedge clk);
        ascii_code = 8'h55;
        @(negedge clk);
        data_valid = 1'b0;
        check("mid_ready_full", 32'(data_ready), 32'd0);
        repeat (8) @(negedge clk);
        check("mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_ready", 32'(data_ready), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle(2 * FLEN);
        send_frame(8'h39, exp_frame(8'h39));
        @(negedge clk);

`ifdef UART_PARITY_EN
        // 43 has three ones -> parity 1; 33 has four ones -> parity 0.
        send_frame(8'h43, {1'b1, 1'b1, 8'h43, 1'b0});
        @(negedge clk);
        send_frame(8'h33, {1'b1, 1'b0, 8'h33, 1'b0});
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
